// File: rtl/sample_buf_sequencer.sv
// Sequencer for the 4-lane sample buffer.
// Loads a DEPTH-sample burst, then replays it as num_passes back-to-back read passes.
// Read passes carry framing that is aligned to the buffer's registered read data.
module sample_buf_sequencer #(
   parameter int unsigned DEPTH = 128,
   parameter int unsigned PW    = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     load_start,
   input  logic                     in_valid,
   output logic                     load_ready,
   output logic                     load_done,
   output logic                     load_err,
   output logic                     loaded,
   input  logic                     run_start,
   input  logic [PW-1:0]            num_passes,
   input  logic                     pass_ready,
   output logic                     ram_en,
   output logic                     ram_rw,
   output logic                     samp_valid,
   output logic [$clog2(DEPTH)-1:0] samp_idx,
   output logic [PW-1:0]            pass_idx,
   output logic                     pass_first,
   output logic                     pass_last,
   output logic                     run_done,
   output logic                     busy
);

   localparam int unsigned IW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_LOAD    = 2'd1,
      S_RD_WAIT = 2'd2,
      S_READ    = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic            loaded_q, loaded_d;
   logic [IW-1:0]   wr_cnt_q, wr_cnt_d;
   logic [IW-1:0]   rd_cnt_q, rd_cnt_d;
   logic [PW-1:0]   num_passes_q, num_passes_d;
   logic [PW-1:0]   pass_idx_q, pass_idx_d;
   logic            load_done_q, load_done_d;
   logic            load_err_q, load_err_d;
   logic            run_done_q, run_done_d;
   logic            samp_valid_q, samp_valid_d;
   logic [IW-1:0]   samp_idx_q, samp_idx_d;
   logic            pass_first_q, pass_first_d;
   logic            pass_last_q, pass_last_d;
   logic            busy_q, busy_d;
   logic            load_ready_q, load_ready_d;

   // State and pipeline registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         loaded_q     <= 1'b0;
         wr_cnt_q     <= '0;
         rd_cnt_q     <= '0;
         num_passes_q <= '0;
         pass_idx_q   <= '0;
         load_done_q  <= 1'b0;
         load_err_q   <= 1'b0;
         run_done_q   <= 1'b0;
         samp_valid_q <= 1'b0;
         samp_idx_q   <= '0;
         pass_first_q <= 1'b0;
         pass_last_q  <= 1'b0;
         busy_q       <= 1'b0;
         load_ready_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         loaded_q     <= loaded_d;
         wr_cnt_q     <= wr_cnt_d;
         rd_cnt_q     <= rd_cnt_d;
         num_passes_q <= num_passes_d;
         pass_idx_q   <= pass_idx_d;
         load_done_q  <= load_done_d;
         load_err_q   <= load_err_d;
         run_done_q   <= run_done_d;
         samp_valid_q <= samp_valid_d;
         samp_idx_q   <= samp_idx_d;
         pass_first_q <= pass_first_d;
         pass_last_q  <= pass_last_d;
         busy_q       <= busy_d;
         load_ready_q <= load_ready_d;
      end
   end

   // Next-state, buffer strobes and output pipeline
   always_comb begin
      state_d      = state_q;
      loaded_d     = loaded_q;
      wr_cnt_d     = wr_cnt_q;
      rd_cnt_d     = rd_cnt_q;
      num_passes_d = num_passes_q;
      pass_idx_d   = pass_idx_q;
      load_done_d  = 1'b0;
      load_err_d   = 1'b0;
      run_done_d   = 1'b0;
      ram_en       = 1'b0;
      ram_rw       = 1'b0;

      // Pass number moves on once the last sample of a pass has been presented
      if (pass_last_q) begin
         pass_idx_d = pass_idx_q + PW'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (load_start) begin
               state_d  = S_LOAD;
               loaded_d = 1'b0;
               wr_cnt_d = '0;
            end else if (run_start && loaded_q) begin
               num_passes_d = num_passes;
               pass_idx_d   = '0;
               if (num_passes == '0) begin
                  run_done_d = 1'b1;
               end else begin
                  state_d = S_RD_WAIT;
               end
            end
         end
         S_LOAD: begin
            ram_rw = 1'b1;
            ram_en = in_valid;
            if (in_valid) begin
               wr_cnt_d = wr_cnt_q + IW'(1);
               if (wr_cnt_q == IW'(DEPTH - 1)) begin
                  state_d     = S_IDLE;
                  load_done_d = 1'b1;
                  loaded_d    = 1'b1;
               end
            end else if (wr_cnt_q != '0) begin
               // A gap after the burst started breaks address continuity
               state_d    = S_IDLE;
               load_err_d = 1'b1;
            end
         end
         S_RD_WAIT: begin
            if (pass_ready) begin
               state_d  = S_READ;
               rd_cnt_d = '0;
            end
         end
         S_READ: begin
            ram_en   = 1'b1;
            rd_cnt_d = rd_cnt_q + IW'(1);
            if (rd_cnt_q == IW'(DEPTH - 1)) begin
               if (pass_idx_q == num_passes_q - PW'(1)) begin
                  state_d    = S_IDLE;
                  run_done_d = 1'b1;
               end else begin
                  state_d = S_RD_WAIT;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      samp_valid_d = (state_q == S_READ);
      samp_idx_d   = rd_cnt_q;
      pass_first_d = (state_q == S_READ) && (rd_cnt_q == '0);
      pass_last_d  = (state_q == S_READ) && (rd_cnt_q == IW'(DEPTH - 1));
      busy_d       = (state_d != S_IDLE);
      load_ready_d = (state_d == S_LOAD);
   end

   assign load_ready = load_ready_q;
   assign load_done  = load_done_q;
   assign load_err   = load_err_q;
   assign loaded     = loaded_q;
   assign samp_valid = samp_valid_q;
   assign samp_idx   = samp_idx_q;
   assign pass_idx   = pass_idx_q;
   assign pass_first = pass_first_q;
   assign pass_last  = pass_last_q;
   assign run_done   = run_done_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_sample_buf_sequencer.sv
// Directed bench for sample_buf_sequencer with a behavioural model of the buffer.
module tb_sample_buf_sequencer;

   localparam int unsigned DEPTH = 128;
   localparam int unsigned PW    = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          load_start, in_valid, run_start, pass_ready;
   logic [PW-1:0] num_passes;
   logic          load_ready, load_done, load_err, loaded;
   logic          ram_en, ram_rw, samp_valid, pass_first, pass_last, run_done, busy;
   logic [6:0]    samp_idx;
   logic [PW-1:0] pass_idx;

   logic [31:0] din;
   logic [31:0] buf_q;
   logic [31:0] mem [DEPTH];
   logic [6:0]  addr = '0;
   logic [31:0] exp_data [DEPTH];

   int n_vec = 0;
   int n_err = 0;
   int en_cycles = 0;
   int en_bursts = 0;
   logic en_prev = 1'b0;

   sample_buf_sequencer #(.DEPTH(DEPTH), .PW(PW)) dut (
      .clk(clk), .rst(rst),
      .load_start(load_start), .in_valid(in_valid),
      .load_ready(load_ready), .load_done(load_done), .load_err(load_err), .loaded(loaded),
      .run_start(run_start), .num_passes(num_passes), .pass_ready(pass_ready),
      .ram_en(ram_en), .ram_rw(ram_rw),
      .samp_valid(samp_valid), .samp_idx(samp_idx), .pass_idx(pass_idx),
      .pass_first(pass_first), .pass_last(pass_last),
      .run_done(run_done), .busy(busy)
   );

   always #5 clk = ~clk;

   // Buffer model: address advances while enabled, clears while disabled, registered read
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_rw) mem[addr] <= din;
         else        buf_q     <= mem[addr];
         addr <= addr + 7'd1;
      end else begin
         addr <= '0;
      end
   end

   // Enable activity counters
   always @(posedge clk) begin
      if (ram_en) en_cycles = en_cycles + 1;
      if (ram_en && !en_prev) en_bursts = en_bursts + 1;
      en_prev = ram_en;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed no finish, expected finish before timeout");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mk(input logic [7:0] s, input int i);
      logic [7:0] b;
      b = 8'(i);
      return {b ^ s, b + s, ~b, b};
   endfunction

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ready"},  32'(load_ready), 32'd0);
      chk({tag, "_done"},   32'(load_done),  32'd0);
      chk({tag, "_err"},    32'(load_err),   32'd0);
      chk({tag, "_loaded"}, 32'(loaded),     32'd0);
      chk({tag, "_ram_en"}, 32'(ram_en),     32'd0);
      chk({tag, "_ram_rw"}, 32'(ram_rw),     32'd0);
      chk({tag, "_valid"},  32'(samp_valid), 32'd0);
      chk({tag, "_idx"},    32'(samp_idx),   32'd0);
      chk({tag, "_pidx"},   32'(pass_idx),   32'd0);
      chk({tag, "_first"},  32'(pass_first), 32'd0);
      chk({tag, "_last"},   32'(pass_last),  32'd0);
      chk({tag, "_rdone"},  32'(run_done),   32'd0);
      chk({tag, "_busy"},   32'(busy),       32'd0);
   endtask

   task automatic do_load(input logic [7:0] seed, input int n_acc, input bit with_run);
      int c0, b0;
      c0 = en_cycles;
      b0 = en_bursts;
      load_start = 1'b1;
      run_start  = with_run;
      num_passes = PW'(1);
      tick;
      load_start = 1'b0;
      run_start  = 1'b0;
      in_valid   = 1'b0;
      chk("ld_ready", 32'(load_ready), 32'd1);
      chk("ld_busy",  32'(busy),       32'd1);
      chk("ld_clr",   32'(loaded),     32'd0);
      // Idle before the first accept just waits
      repeat (3) tick;
      chk("ld_wait_ready", 32'(load_ready), 32'd1);
      chk("ld_wait_en",    32'(en_cycles - c0), 32'd0);
      for (int i = 0; i < n_acc; i++) begin
         in_valid    = 1'b1;
         din         = mk(seed, i);
         exp_data[i] = din;
         tick;
      end
      in_valid = 1'b0;
      if (n_acc == int'(DEPTH)) begin
         chk("ld_done",     32'(load_done),  32'd1);
         chk("ld_loaded",   32'(loaded),     32'd1);
         chk("ld_ready_lo", 32'(load_ready), 32'd0);
         chk("ld_busy_lo",  32'(busy),       32'd0);
         chk("ld_en_cyc",   32'(en_cycles - c0), 32'd128);
         chk("ld_en_burst", 32'(en_bursts - b0), 32'd1);
         tick;
         chk("ld_done_pulse", 32'(load_done), 32'd0);
         chk("ld_loaded_hold", 32'(loaded),   32'd1);
      end else begin
         #1;
         chk("ab_ram_en", 32'(ram_en),     32'd0);
         chk("ab_ready",  32'(load_ready), 32'd1);
         tick;
         chk("ab_err",     32'(load_err),  32'd1);
         chk("ab_done",    32'(load_done), 32'd0);
         chk("ab_loaded",  32'(loaded),    32'd0);
         chk("ab_busy",    32'(busy),      32'd0);
         chk("ab_en_cyc",  32'(en_cycles - c0), 32'(n_acc));
         tick;
         chk("ab_err_pulse", 32'(load_err), 32'd0);
      end
   endtask

   task automatic do_run(input int n, input int bp);
      int  cyc, vcnt, eidx, epass, stall, last_first, done_cyc, c0, b0;
      bit  done;
      c0 = en_cycles;
      b0 = en_bursts;
      num_passes = PW'(n);
      run_start  = 1'b1;
      pass_ready = 1'b1;
      tick;
      run_start = 1'b0;
      chk("run_busy", 32'(busy), 32'd1);
      cyc = 0; vcnt = 0; eidx = 0; epass = 0; stall = 0;
      last_first = -1; done = 1'b0; done_cyc = -1;
      while (!done && cyc < 129 * n + bp + 40) begin
         tick;
         cyc++;
         if (samp_valid) begin
            chk("rd_idx",   32'(samp_idx),   32'(eidx));
            chk("rd_pass",  32'(pass_idx),   32'(epass));
            chk("rd_data",  buf_q,           exp_data[eidx]);
            chk("rd_first", 32'(pass_first), 32'(eidx == 0));
            chk("rd_last",  32'(pass_last),  32'(eidx == 127));
            chk("rd_rdone", 32'(run_done),   32'(eidx == 127 && epass == n - 1));
            if (eidx == 0) begin
               if (last_first >= 0)
                  chk("rd_period", 32'(cyc - last_first), 32'((epass == 1) ? 129 + bp : 129));
               else
                  chk("rd_lat", 32'(cyc), 32'd2);
               last_first = cyc;
            end
            if (eidx == 127 && epass == 0 && bp > 0) stall = bp;
            vcnt++;
            if (eidx == 127) begin
               eidx = 0;
               epass++;
            end else begin
               eidx++;
            end
         end
         if (run_done) begin
            done     = 1'b1;
            done_cyc = cyc;
         end
         if (stall > 0) begin
            pass_ready = 1'b0;
            stall--;
            chk("bp_ram_en", 32'(ram_en), 32'd0);
            chk("bp_busy",   32'(busy),   32'd1);
         end else begin
            pass_ready = 1'b1;
         end
      end
      chk("run_seen_done", 32'(done),      32'd1);
      chk("run_done_cyc",  32'(done_cyc),  32'(129 * n + bp));
      chk("run_nvalid",    32'(vcnt),      32'(128 * n));
      chk("run_en_cyc",    32'(en_cycles - c0), 32'(128 * n));
      chk("run_en_burst",  32'(en_bursts - b0), 32'(n));
      tick;
      chk("run_done_pulse", 32'(run_done),   32'd0);
      chk("run_idle",       32'(busy),       32'd0);
      chk("run_valid_lo",   32'(samp_valid), 32'd0);
   endtask

   initial begin
      bit found;
      rst = 1'b1; load_start = 1'b0; in_valid = 1'b0; run_start = 1'b0;
      pass_ready = 1'b0; num_passes = '0; din = '0;
      tick;
      tick;
      rst = 1'b0;
      chk_all_zero("rst");

      // Run request without a loaded buffer is ignored
      run_start = 1'b1; num_passes = PW'(1);
      tick;
      run_start = 1'b0;
      chk("nl_busy",  32'(busy),     32'd0);
      chk("nl_rdone", 32'(run_done), 32'd0);
      tick;
      chk("nl_rdone2", 32'(run_done), 32'd0);
      chk("nl_ram_en", 32'(ram_en),   32'd0);

      do_load(8'h11, 50, 1'b0);
      do_load(8'h22, 128, 1'b0);
      do_run(3, 0);
      do_run(2, 20);

      // Zero-pass run completes immediately from IDLE
      run_start = 1'b1; num_passes = '0;
      tick;
      run_start = 1'b0;
      chk("zp_rdone", 32'(run_done), 32'd1);
      chk("zp_busy",  32'(busy),     32'd0);
      tick;
      chk("zp_rdone_pulse", 32'(run_done), 32'd0);
      chk("zp_loaded",      32'(loaded),   32'd1);

      // Simultaneous load and run: load wins
      do_load(8'h33, 128, 1'b1);
      do_run(1, 0);

      // Reset in the middle of a read pass
      num_passes = PW'(2); run_start = 1'b1; pass_ready = 1'b1;
      tick;
      run_start = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 400; k++) begin
         tick;
         if (samp_valid && samp_idx == 7'd60) begin
            found = 1'b1;
            break;
         end
      end
      chk("mr_found", 32'(found), 32'd1);
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk_all_zero("mr");
      tick;
      chk("mr_rdone_after", 32'(run_done), 32'd0);
      chk("mr_ram_en_after", 32'(ram_en),  32'd0);
      do_load(8'h44, 128, 1'b0);
      do_run(1, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
